// File: rtl/inv_key_schedule.sv
// inv_key_schedule: walks an AES-128 key schedule backwards, starting from the
// round-10 key and emitting round keys 10 down to 0 over a valid/ready handshake.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start     - one-cycle request to begin a reverse schedule (honoured in IDLE only)
//   last_key  - round-10 key, word 0 in [127:96]; captured when start is accepted
//   rk_ready  - consumer accepts rk_out this cycle
//   rk_valid  - rk_out/rk_round hold a valid round key
//   rk_out    - current round key, same word order as last_key
//   rk_round  - round index of rk_out (10 .. 0)
//   busy      - high while keys are being emitted
//   done      - one-cycle pulse in the cycle after the round-0 transfer
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EMIT   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [STATE_W-1:0] state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer_c;
    logic [WORD_W-1:0]  w0_c, w1_c, w2_c, w3_c;
    logic [WORD_W-1:0]  p0_c, p1_c, p2_c, p3_c;
    logic [WORD_W-1:0]  rot_c, sub_c, g_c;
    logic [BYTE_W-1:0]  rcon_c;
    logic [KEY_W-1:0]   prev_key_c;

    // Handshake: a transfer happens whenever a key is shown and the consumer is ready.
    assign xfer_c = (state_q == EMIT) && rk_ready;

    // Split the current round key into its four words.
    assign w0_c = key_q[127:96];
    assign w1_c = key_q[95:64];
    assign w2_c = key_q[63:32];
    assign w3_c = key_q[31:0];

    // Undo the forward XOR chain; the last word of the previous round feeds G.
    assign p3_c = w3_c ^ w2_c;
    assign p2_c = w2_c ^ w1_c;
    assign p1_c = w1_c ^ w0_c;

    // RotWord: bytes b0 b1 b2 b3 -> b1 b2 b3 b0, b0 being the top byte.
    assign rot_c = {p3_c[23:0], p3_c[31:24]};

    // SubWord: one S-box per byte.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        S_box u_sbox (
            .in_i  (rot_c[BYTE_W*b +: BYTE_W]),
            .out_o (sub_c[BYTE_W*b +: BYTE_W])
        );
    end

    // Round constant for the round being left; it is the one that produced key_q.
    always_comb begin
        rcon_c = 8'h00;
        case (round_q)
            4'd1:    rcon_c = 8'h01;
            4'd2:    rcon_c = 8'h02;
            4'd3:    rcon_c = 8'h04;
            4'd4:    rcon_c = 8'h08;
            4'd5:    rcon_c = 8'h10;
            4'd6:    rcon_c = 8'h20;
            4'd7:    rcon_c = 8'h40;
            4'd8:    rcon_c = 8'h80;
            4'd9:    rcon_c = 8'h1b;
            4'd10:   rcon_c = 8'h36;
            default: rcon_c = 8'h00;
        endcase
    end

    assign g_c        = sub_c ^ {rcon_c, 24'h000000};
    assign p0_c       = w0_c ^ g_c;
    assign prev_key_c = {p0_c, p1_c, p2_c, p3_c};

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; flags are decoded from the next state so they register in step.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_key;
                    round_d = LAST_ROUND;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer_c) begin
                    if (round_q == '0) begin
                        // Round-0 key stays on rk_out so the final value remains observable.
                        state_d = FINISH;
                    end else begin
                        key_d   = prev_key_c;
                        round_d = round_q - ROUND_W'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == EMIT);
        busy_d  = (state_d == EMIT);
        done_d  = (state_d == FINISH);
    end

    assign rk_valid = valid_q;
    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// S_box: AES forward S-box, purely combinational byte lookup.
//
// Ports:
//   in_i  - input byte
//   out_o - substituted byte
module S_box (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: table-driven and randomized check of inv_key_schedule
// against an AES key-expansion model built from GF(2^8) arithmetic.
module tb_inv_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [11];

    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO_R9  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;

    typedef struct {
        logic [127:0] key;
        logic [127:0] r9;
        logic [127:0] r0;
        bit           known;
        bit           rand_ready;
        bit           poke;
    } vec_t;

    inv_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model: GF(2^8) and AES key expansion ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input int j);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < j; k++) r = xt(r);
        return r;
    endfunction

    function automatic logic [31:0] g_ref(input logic [31:0] w, input int j);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        r = {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
        return r ^ {rcon_ref(j), 24'h000000};
    endfunction

    // Forward expansion from a cipher key; returns the round-10 key.
    function automatic logic [127:0] fwd_r10(input logic [127:0] k0);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++)
            w[i] = w[i-4] ^ ((i % 4 == 0) ? g_ref(w[i-1], i / 4) : w[i-1]);
        return {w[40], w[41], w[42], w[43]};
    endfunction

    // Solve the expansion recurrence backwards; exp_rk[k] is the key of round 10-k.
    task automatic model_rev(input logic [127:0] k10);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
        for (int i = 43; i >= 4; i--)
            w[i-4] = w[i] ^ ((i % 4 == 0) ? g_ref(w[i-1], i / 4) : w[i-1]);
        for (int r = 0; r <= 10; r++)
            exp_rk[10-r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One complete run: start, follow every shown key, record transfers, expect done.
    task automatic run_seq(input logic [127:0] key, input bit rand_ready, input bit poke);
        int idx;
        int cyc;
        bit fin;
        bit poked;
        model_rev(key);
        for (int k = 0; k < 11; k++) got_rk[k] = 'x;
        idx = 0; cyc = 0; fin = 0; poked = 0;
        @(negedge clk);
        start    = 1'b1;
        last_key = key;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk("xfer_count", 128'(idx), 128'd11);
                if (!rand_ready) chk("done_latency", 128'(cyc), 128'd12);
                chk("busy_at_done", 128'(busy), 128'd0);
                chk("valid_at_done", 128'(rk_valid), 128'd0);
                fin = 1;
            end else if (idx < 11) begin
                chk("rk_valid", 128'(rk_valid), 128'd1);
                chk("busy", 128'(busy), 128'd1);
                chk("rk_round", 128'(rk_round), 128'(10 - idx));
                chk("rk_out", rk_out, exp_rk[idx]);
            end else begin
                chk("done_after_round0", 128'(done), 128'd1);
            end
            if (!fin && cyc >= 300) begin
                chk("run_timeout", 128'd0, 128'd1);
                fin = 1;
            end
            if (!fin) begin
                start    = 1'b0;
                last_key = rand128();
                if (poke && idx == 5 && !poked) begin
                    start    = 1'b1;
                    last_key = ~key;
                    poked    = 1;
                end
                rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (idx < 11 && rk_ready) begin
                    got_rk[idx] = rk_out;
                    idx++;
                end
            end
        end
        // The recovered cipher key must expand forward to the original round-10 key.
        chk("fwd_of_round0", fwd_r10(got_rk[10]), key);
    endtask

    vec_t vecs [6];

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 256; a++) sbox_t[a] = sbox_calc(8'(a));

        vecs[0] = '{FIPS_R10, FIPS_R9, FIPS_R0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{FIPS_R10, FIPS_R9, FIPS_R0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{FIPS_R10, FIPS_R9, FIPS_R0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{ZERO_R10, ZERO_R9, 128'h0,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{128'h0,   128'h0,  128'h0,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{128'h0,   128'h0,  128'h0,  1'b0, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; last_key = '0; rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 128'(rk_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_rk_out", rk_out, 128'd0);
        chk("reset_rk_round", 128'(rk_round), 128'd0);

        // Start presented together with reset release is taken on the very next edge.
        rst = 1'b0; start = 1'b1; last_key = FIPS_R10;
        @(negedge clk);
        start = 1'b0;
        chk("first_start_valid", 128'(rk_valid), 128'd1);
        chk("first_start_round", 128'(rk_round), 128'd10);
        chk("first_start_key", rk_out, FIPS_R10);
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 128'(rk_valid), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_seq(vecs[v].key, vecs[v].rand_ready, vecs[v].poke);
            if (vecs[v].known) begin
                chk("tbl_round10", got_rk[0], vecs[v].key);
                chk("tbl_round9", got_rk[1], vecs[v].r9);
                chk("tbl_round0", got_rk[10], vecs[v].r0);
            end
        end

        for (int n = 0; n < 4; n++) run_seq(rand128(), n[0], n[1]);

        // Abort at round 3, confirm silence, then a fresh start replays from round 10.
        begin
            bit found = 0;
            @(negedge clk);
            start = 1'b1; last_key = FIPS_R10; rk_ready = 1'b1;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (rk_valid && rk_round == 4'd3) found = 1;
            end
            chk("abort_round3_reached", 128'(found), 128'd1);
            rst = 1'b1;
            #1;
            chk("abort_valid", 128'(rk_valid), 128'd0);
            chk("abort_busy", 128'(busy), 128'd0);
            chk("abort_done", 128'(done), 128'd0);
            chk("abort_rk_out", rk_out, 128'd0);
            chk("abort_rk_round", 128'(rk_round), 128'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("silent_after_abort", 128'({rk_valid, busy, done}), 128'd0);
            end
            run_seq(FIPS_R10, 1'b0, 1'b0);
            chk("replay_round0", got_rk[10], FIPS_R0);
        end

        // Back-to-back: second start lands in the cycle right after done.
        run_seq(ZERO_R10, 1'b0, 1'b0);
        run_seq(FIPS_R10, 1'b0, 1'b0);
        chk("b2b_round9", got_rk[1], FIPS_R9);
        @(negedge clk);
        chk("b2b_done_single", 128'(done), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
